// File: rtl/fixed_dot_ctrl.sv
// -----------------------------------------------------------------------------
// fixed_dot_ctrl
//
// Sequential signed fixed-point dot-product engine. A start command loads the
// number of element pairs (len). The block then accepts up to one Q8.8 pair
// per cycle, registers the full Q16.16 product and adds it into a wide
// Q(ACC_W-16).16 accumulator. The final value is presented as a saturated
// Q8.8 result with an overflow flag until the consumer takes it.
//
// State flow:  IDLE -> RUN -> DRAIN -> DONE -> IDLE
//              IDLE -> DONE                      (len == 0)
//
// Ports
//   clk        single clock; all state updates on the rising edge
//   rst        synchronous, active-high reset
//   start      begin a dot product (honoured only in IDLE)
//   len[4:0]   number of element pairs, sampled when start is honoured
//   in_valid   element pair a/b present
//   in_ready   block accepts a pair this cycle (high in RUN)
//   a[15:0]    signed Q8.8 operand
//   b[15:0]    signed Q8.8 operand
//   out_valid  result available (high in DONE)
//   out_ready  consumer takes result
//   result     signed Q8.8 saturated dot product, 0 when out_valid is low
//   overflow   result was saturated, 0 when out_valid is low
//   busy       high in any state other than IDLE
//
// Parameter
//   ACC_W      accumulator width. Must exceed 32 so that the product can be
//              sign-extended; 36 or more guarantees no wrap for len <= 31.
// -----------------------------------------------------------------------------
module fixed_dot_ctrl #(
   parameter int ACC_W = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [4:0]  len,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] result,
   output logic        overflow,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                   state_q, state_d;
   logic [4:0]               cnt_q;
   logic signed [31:0]       prod_q;
   logic                     pvld_q;
   logic signed [ACC_W-1:0]  acc_q;

   logic                     accept;
   logic                     acc_clr;
   logic signed [31:0]       a_w, b_w;
   logic signed [ACC_W-1:0]  prod_ext;
   logic [ACC_W-24:0]        acc_hi;
   logic                     in_range;
   logic [15:0]              sat_res;

   // ---------------------------------------------------------------------------
   // Next-state and control decode
   // ---------------------------------------------------------------------------
   // NOTE: every signal driven here gets a default before the case statement,
   // so no path through the block leaves one unassigned and no latch appears.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      acc_clr   = 1'b0;
      unique case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               acc_clr = 1'b1;
               state_d = (len == 5'd0) ? DONE : RUN;
            end
         end
         RUN: begin
            in_ready = 1'b1;
            // The last pair leaves one product still in the product register,
            // which DRAIN gives a cycle to land in the accumulator.
            if (in_valid && (cnt_q == 5'd1)) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign accept = in_valid && in_ready;

   // Operands widened to 32 bits so the 32-bit product is exact.
   assign a_w      = {{16{a[15]}}, a};
   assign b_w      = {{16{b[15]}}, b};
   assign prod_ext = {{(ACC_W-32){prod_q[31]}}, prod_q};

   // ---------------------------------------------------------------------------
   // State, count, product pipeline and accumulator
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         prod_q  <= 32'sd0;
         pvld_q  <= 1'b0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;

         if (acc_clr) begin
            cnt_q <= len;
         end else if (accept) begin
            cnt_q <= cnt_q - 5'd1;
         end

         pvld_q <= accept;
         if (accept) begin
            prod_q <= a_w * b_w;
         end

         if (acc_clr) begin
            acc_q <= '0;
         end else if (pvld_q) begin
            acc_q <= acc_q + prod_ext;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Saturation to Q8.8
   // ---------------------------------------------------------------------------
   // The accumulator fits Q8.8 after dropping 8 fraction bits when bits
   // [ACC_W-1:23] are all copies of the sign. Dropping the low bits of a
   // two's-complement value floors toward negative infinity.
   assign acc_hi   = acc_q[ACC_W-1:23];
   assign in_range = (&acc_hi) || !(|acc_hi);
   assign sat_res  = in_range          ? acc_q[23:8] :
                     acc_q[ACC_W-1]    ? 16'h8000    :
                                         16'h7FFF;

   assign result   = out_valid ? sat_res : 16'h0000;
   assign overflow = out_valid && !in_range;

endmodule

// File: tb/tb_fixed_dot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fixed_dot_ctrl
//
// Directed bench for fixed_dot_ctrl. Each run pushes its hand-computed result
// into a scoreboard queue; an independent monitor pops and compares whenever
// a result is handed over (out_valid && out_ready). Latency, stall, hold and
// reset behaviour are checked inline by the stimulus process.
// -----------------------------------------------------------------------------
module tb_fixed_dot_ctrl;

   localparam int ACC_W = 40;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [4:0]  len;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic        overflow;
   logic        busy;

   typedef struct packed {
      logic [15:0] res;
      logic        ovf;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] va[32];
   logic [15:0] vb[32];
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;

   fixed_dot_ctrl #(.ACC_W(ACC_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .overflow  (overflow),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares every handed-over result against the scoreboard and
   // confirms result/overflow read zero whenever out_valid is low.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_result: got 0x%0h with no run pending", result);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("result", 32'(result), 32'(e.res));
               check("overflow", 32'(overflow), 32'(e.ovf));
            end
         end else if (!out_valid) begin
            check("idle_zero", {15'd0, result, overflow}, 32'd0);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_result"}, 32'(result), 32'd0);
      check({tag, "_overflow"}, 32'(overflow), 32'd0);
   endtask

   // One complete dot product using va/vb. gaps drops in_valid every other
   // cycle; hold keeps out_ready low for that many DONE cycles while start is
   // pulsed; elat < 0 skips the latency check.
   task automatic run_vec(input int n, input bit gaps, input int hold,
                          input logic [15:0] er, input logic eo, input int elat);
      int   s_cyc;
      int   i;
      int   budget;
      int   lat;
      bit   seen;
      bit   ph;
      exp_t e;
      @(posedge clk); #1;
      start     = 1'b1;
      len       = 5'(n);
      out_ready = (hold == 0);
      s_cyc     = cyc;
      e.res     = er;
      e.ovf     = eo;
      sb.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      len   = 5'd0;
      i      = 0;
      budget = 0;
      ph     = 1'b0;
      while (i < n && budget < 200) begin
         in_valid = !(gaps && ph);
         ph       = !ph;
         a        = va[i];
         b        = vb[i];
         @(negedge clk);
         check("busy_run", 32'(busy), 32'd1);
         if (in_valid && in_ready) i++;
         @(posedge clk); #1;
         budget++;
      end
      in_valid = 1'b0;
      if (i < n) begin
         checks++;
         failures++;
         $display("FAIL feed_timeout: accepted %0d of %0d pairs", i, n);
      end
      seen = 1'b0;
      lat  = 0;
      for (int k = 0; k < 100 && !seen; k++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1;
            lat  = cyc - s_cyc;
         end
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL out_valid_timeout: no result for len=%0d", n);
      end else if (elat >= 0) begin
         check("latency", 32'(lat), 32'(elat));
      end
      if (hold > 0) begin
         for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            start = (h % 2 == 0);
            len   = 5'd7;
            @(negedge clk);
            check("hold_result", 32'(result), 32'(er));
            check("hold_overflow", 32'(overflow), 32'(eo));
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_busy", 32'(busy), 32'd1);
         end
         @(posedge clk); #1;
         start     = 1'b0;
         len       = 5'd0;
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      @(negedge clk);
      check("back_to_idle_busy", 32'(busy), 32'd0);
   endtask

   // Starts a run of n pairs, lets k pairs in, then applies reset.
   task automatic abort_run(input int n, input int k, input string tag);
      @(posedge clk); #1;
      start     = 1'b1;
      len       = 5'(n);
      out_ready = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      in_valid = 1'b1;
      a        = 16'h7000;
      b        = 16'h7000;
      repeat (k) begin
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_all_zero(tag);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      len       = 5'd0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = 16'h0000;
      b         = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("reset");

      // 1.0 * 1.5 = 1.5
      va[0] = 16'h0100; vb[0] = 16'h0180;
      run_vec(1, 1'b0, 0, 16'h0180, 1'b0, 3);

      // 4 * (2.0 * 3.0) = 24.0
      for (int i = 0; i < 4; i++) begin va[i] = 16'h0200; vb[i] = 16'h0300; end
      run_vec(4, 1'b0, 0, 16'h1800, 1'b0, 6);

      // 2 * 64 * 64 saturates high; 2 * 64 * -64 saturates low
      for (int i = 0; i < 2; i++) begin va[i] = 16'h4000; vb[i] = 16'h4000; end
      run_vec(2, 1'b0, 0, 16'h7FFF, 1'b1, 4);
      for (int i = 0; i < 2; i++) begin va[i] = 16'h4000; vb[i] = 16'hC000; end
      run_vec(2, 1'b0, 0, 16'h8000, 1'b1, 4);

      // -1/256 * 0.5 = -1/512 floors to -1/256
      va[0] = 16'hFFFF; vb[0] = 16'h0080;
      run_vec(1, 1'b0, 0, 16'hFFFF, 1'b0, 3);

      // len = 0 gives zero in cycle 1
      run_vec(0, 1'b0, 0, 16'h0000, 1'b0, 1);

      // Range edges: 2^23-256 fits, 2^23 saturates, -2^23 fits
      va[0] = 16'h7FFF; vb[0] = 16'h0100;
      run_vec(1, 1'b0, 0, 16'h7FFF, 1'b0, 3);
      va[1] = 16'h0001; vb[1] = 16'h0100;
      run_vec(2, 1'b0, 0, 16'h7FFF, 1'b1, 4);
      va[0] = 16'h8000; vb[0] = 16'h0100;
      run_vec(1, 1'b0, 0, 16'h8000, 1'b0, 3);

      // Longest run: 31 * (-128 * -128) must not wrap
      for (int i = 0; i < 31; i++) begin va[i] = 16'h8000; vb[i] = 16'h8000; end
      run_vec(31, 1'b0, 0, 16'h7FFF, 1'b1, 33);

      // Stalled input then held output with ignored start:
      // 1.0*2.0 + (-1.0)*1.0 + 0.5*0.5 = 1.25
      va[0] = 16'h0100; vb[0] = 16'h0200;
      va[1] = 16'hFF00; vb[1] = 16'h0100;
      va[2] = 16'h0080; vb[2] = 16'h0080;
      run_vec(3, 1'b1, 5, 16'h0140, 1'b0, -1);

      // Reset mid-RUN, then a clean run shows no residue
      abort_run(4, 2, "rst_run");
      va[0] = 16'h0100; vb[0] = 16'h0100;
      run_vec(1, 1'b0, 0, 16'h0100, 1'b0, 3);

      // Reset in DRAIN
      abort_run(1, 1, "rst_drain");
      va[0] = 16'h0100; vb[0] = 16'h0100;
      run_vec(1, 1'b0, 0, 16'h0100, 1'b0, 3);

      // Reset in DONE while the result is still held
      @(posedge clk); #1;
      out_ready = 1'b0;
      start     = 1'b1;
      len       = 5'd0;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("done_before_rst", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check_all_zero("rst_done");
      va[0] = 16'h0100; vb[0] = 16'h0100;
      run_vec(1, 1'b0, 0, 16'h0100, 1'b0, 3);

      repeat (2) @(posedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fixed_dot_ctrl.md
FIXED_DOT_CTRL -- requirements
Module: fixed_dot_ctrl

Interface
REQ-001 SHALL have parameter ACC_W, default 40, accumulator width in bits (signed Q(ACC_W-16).16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  begin a dot product; honoured only in IDLE.
REQ-005 SHALL have port len  input  5  number of element pairs, 0..31; sampled when start is honoured.
REQ-006 SHALL have port in_valid  input  1  element pair a/b present.
REQ-007 SHALL have port in_ready  output  1  block accepts a pair this cycle.
REQ-008 SHALL have port a  input  16  signed Q8.8 operand.
REQ-009 SHALL have port b  input  16  signed Q8.8 operand.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port result  output  16  signed Q8.8 saturated dot product.
REQ-013 SHALL have port overflow  output  1  result was saturated.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-016 IDLE: in_ready=0, out_valid=0; start with len>0 -> RUN, acc cleared, remaining count loaded with len; start with len=0 -> DONE, acc cleared.
REQ-017 RUN: in_ready=1; a pair is accepted on in_valid&&in_ready; each accept decrements the count; accept with count==1 -> DRAIN.
REQ-018 Accepted pair SHALL register the full 32-bit signed product a*b (Q16.16) into a product register with a product-valid flag, one cycle after the accept.
REQ-019 Every cycle the product-valid flag is set, acc SHALL add the sign-extended product register; no pair is dropped, and full throughput is one pair per cycle.
REQ-020 DRAIN: in_ready=0; lasts exactly one cycle while the final product accumulates, then -> DONE.
REQ-021 DONE: out_valid=1; result and overflow are held stable until out_valid&&out_ready, then -> IDLE.
REQ-022 result SHALL equal acc[23:8] (arithmetic truncation toward negative infinity) when acc lies in [-2^23, 2^23-1].
REQ-023 acc above range SHALL give result 0x7FFF with overflow=1; acc below range SHALL give 0x8000 with overflow=1; otherwise overflow=0.
REQ-024 The accumulator SHALL NOT wrap for any len<=31 with ACC_W>=36.
REQ-025 Latency: with the final accept in cycle k, out_valid rises in cycle k+2; with start in cycle 0, len=N and in_valid held high, out_valid rises in cycle N+2; with len=0, it rises in cycle 1.
REQ-026 start outside IDLE SHALL be ignored; len and in_valid outside RUN SHALL be ignored.
REQ-027 in_valid gaps in RUN SHALL stall without state change; the accumulated value is unaffected.
REQ-028 result and overflow SHALL read 0 whenever out_valid=0.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE and clear acc, count, the product register and the product-valid flag; any in-flight product is discarded.
REQ-030 After reset, in_ready, out_valid, result, overflow and busy SHALL all be 0, including when reset is applied mid-RUN, mid-DRAIN or in DONE.

Verification
REQ-031 len=1, a=0x0100, b=0x0180, start cycle 0 -> out_valid in cycle 3, result=0x0180, overflow=0.
REQ-032 len=4, four pairs a=0x0200, b=0x0300 back-to-back -> result=0x1800 in cycle 6, overflow=0.
REQ-033 len=2, a=b=0x4000 -> result=0x7FFF, overflow=1; len=2, a=0x4000, b=0xC000 -> result=0x8000, overflow=1.
REQ-034 len=1, a=0xFFFF, b=0x0080 -> result=0xFFFF (floor of -1/512); len=0 -> result=0x0000 in cycle 1.
REQ-035 len=3 with in_valid low every other cycle, then out_ready low for 5 cycles with start pulsed -> correct sum, result stable, start ignored, busy=1 throughout.
REQ-036 rst mid-RUN after 2 accepts -> all outputs 0 next cycle; a fresh start with len=1, a=b=0x0100 -> result=0x0100 with no residue from the aborted run.
